// File: rtl/stable_byte_detector_pkg.sv
// Shared definitions for the stable byte detector: state encoding and default sizing.
package stable_byte_detector_pkg;

    localparam int unsigned DEF_WIDTH     = 8;
    localparam int unsigned DEF_THRESHOLD = 8;
    localparam int unsigned DEF_CNT_WIDTH = 4;

    // 2'd3 is unused and recovers to EMPTY.
    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        TRACKING = 2'd1,
        STABLE   = 2'd2
    } state_t;

endpackage

// File: rtl/stable_byte_detector_ne.sv
// WIDTH-bit not-equal comparator between the live sample and the held sample.
module stable_byte_detector_ne
    import stable_byte_detector_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ne_c
);

    assign ne_c = (a != b);

endmodule

// File: rtl/stable_byte_detector.sv
// Qualifies a slow byte bus: declares it stable after THRESHOLD consecutive
// equal CE samples, then presents the held value with VALID.
module stable_byte_detector
    import stable_byte_detector_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned THRESHOLD = DEF_THRESHOLD,
    parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CE,
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] O,
    output logic             VALID,
    output logic             CHANGED
);

    localparam logic [CNT_WIDTH-1:0] THRESH = CNT_WIDTH'(THRESHOLD);

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     prev, prev_nxt;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0]     o_nxt;
    logic                 valid_nxt;
    logic                 changed_nxt;
    logic                 ne;

    stable_byte_detector_ne #(
        .WIDTH (WIDTH)
    ) u_ne (
        .a    (I),
        .b    (prev),
        .ne_c (ne)
    );

    assign cnt_inc = cnt + CNT_WIDTH'(1);

    // State and datapath registers; reset wins over CE.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= EMPTY;
            prev    <= '0;
            cnt     <= '0;
            O       <= '0;
            VALID   <= 1'b0;
            CHANGED <= 1'b0;
        end else begin
            state   <= state_nxt;
            prev    <= prev_nxt;
            cnt     <= cnt_nxt;
            O       <= o_nxt;
            VALID   <= valid_nxt;
            CHANGED <= changed_nxt;
        end
    end

    // Next-state and next-output logic; CHANGED self-clears every edge.
    always_comb begin
        state_nxt   = state;
        prev_nxt    = prev;
        cnt_nxt     = cnt;
        o_nxt       = O;
        valid_nxt   = VALID;
        changed_nxt = 1'b0;

        if (CE) begin
            unique case (state)
                EMPTY: begin
                    prev_nxt  = I;
                    cnt_nxt   = '0;
                    state_nxt = TRACKING;
                end
                TRACKING: begin
                    if (ne) begin
                        prev_nxt = I;
                        cnt_nxt  = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == THRESH) begin
                            o_nxt     = prev;
                            valid_nxt = 1'b1;
                            state_nxt = STABLE;
                        end
                    end
                end
                STABLE: begin
                    // Equal samples hold everything, so cnt stays at THRESHOLD.
                    if (ne) begin
                        valid_nxt   = 1'b0;
                        changed_nxt = 1'b1;
                        prev_nxt    = I;
                        cnt_nxt     = '0;
                        state_nxt   = TRACKING;
                    end
                end
                default: begin
                    valid_nxt = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stable_byte_detector.sv
// Directed self-checking bench for stable_byte_detector (THRESHOLD=8 and THRESHOLD=1).
module tb_stable_byte_detector;

    logic       clk;
    logic       reset;
    logic       ce;
    logic [7:0] din;
    logic [7:0] o8, o1;
    logic       valid8, valid1;
    logic       changed8, changed1;

    int total  = 0;
    int passed = 0;

    stable_byte_detector dut8 (
        .CLK     (clk),
        .RESET   (reset),
        .CE      (ce),
        .I       (din),
        .O       (o8),
        .VALID   (valid8),
        .CHANGED (changed8)
    );

    stable_byte_detector #(
        .THRESHOLD (1)
    ) dut1 (
        .CLK     (clk),
        .RESET   (reset),
        .CE      (ce),
        .I       (din),
        .O       (o1),
        .VALID   (valid1),
        .CHANGED (changed1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        reset = 1'b1;
        ce    = 1'b1;
        din   = 8'hA5;
        step();
        step();
        check("rst_o", o8, 8'h00);
        check("rst_valid", 8'(valid8), 8'h00);
        check("rst_changed", 8'(changed8), 8'h00);

        // Latency: VALID rises on edge 9 after release.
        reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            check("lat_valid_low", 8'(valid8), 8'h00);
            check("lat_changed", 8'(changed8), 8'h00);
        end
        step();
        check("lat_valid_e9", 8'(valid8), 8'h01);
        check("lat_o_e9", o8, 8'hA5);
        check("lat_changed_e9", 8'(changed8), 8'h00);
        step();
        check("hold_valid", 8'(valid8), 8'h01);

        // Break stability with 8'h5A, then requalify.
        din = 8'h5A;
        step();
        check("chg_pulse", 8'(changed8), 8'h01);
        check("chg_valid", 8'(valid8), 8'h00);
        check("chg_o_old", o8, 8'hA5);
        for (int k = 1; k <= 7; k++) begin
            step();
            check("req_valid_low", 8'(valid8), 8'h00);
            check("req_changed_low", 8'(changed8), 8'h00);
            check("req_o_old", o8, 8'hA5);
        end
        step();
        check("req_valid", 8'(valid8), 8'h01);
        check("req_o", o8, 8'h5A);

        // Reset one cycle after CHANGED rises.
        din = 8'hA5;
        step();
        check("chg2_pulse", 8'(changed8), 8'h01);
        reset = 1'b1;
        step();
        check("rst2_changed", 8'(changed8), 8'h00);
        check("rst2_valid", 8'(valid8), 8'h00);
        check("rst2_o", o8, 8'h00);
        reset = 1'b0;
        step();
        check("empty_changed", 8'(changed8), 8'h00);
        check("empty_valid", 8'(valid8), 8'h00);
        for (int k = 1; k <= 7; k++) step();
        check("rq2_valid_low", 8'(valid8), 8'h00);
        step();
        check("rq2_valid", 8'(valid8), 8'h01);
        check("rq2_o", o8, 8'hA5);

        // Reset during STABLE on the same edge as a change kills the pending pulse.
        din   = 8'h00;
        reset = 1'b1;
        step();
        check("rst3_changed", 8'(changed8), 8'h00);
        check("rst3_valid", 8'(valid8), 8'h00);
        check("rst3_o", o8, 8'h00);
        reset = 1'b0;

        // Glitchy input never qualifies.
        for (int k = 0; k < 24; k++) begin
            din = ((k % 4) == 2) ? 8'h3D : 8'h3C;
            step();
            check("glitch_valid", 8'(valid8), 8'h00);
            check("glitch_o", o8, 8'h00);
            check("glitch_changed", 8'(changed8), 8'h00);
        end

        // CE every other cycle; I disturbed only while CE is low.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            ce  = 1'b1;
            din = 8'hFF;
            step();
            check("ce_valid_hi", 8'(valid8), (n == 9) ? 8'h01 : 8'h00);
            ce  = 1'b0;
            din = 8'h00;
            step();
            check("ce_valid_lo", 8'(valid8), (n == 9) ? 8'h01 : 8'h00);
            check("ce_changed_lo", 8'(changed8), 8'h00);
        end
        check("ce_o", o8, 8'hFF);

        // CHANGED clears on the next edge even with CE low.
        ce  = 1'b1;
        din = 8'h00;
        step();
        check("ce_chg_pulse", 8'(changed8), 8'h01);
        ce = 1'b0;
        step();
        check("ce_chg_clear", 8'(changed8), 8'h00);
        check("ce_chg_valid", 8'(valid8), 8'h00);
        check("ce_chg_o", o8, 8'hFF);

        // THRESHOLD=1 instance.
        ce    = 1'b1;
        reset = 1'b1;
        din   = 8'h81;
        step();
        reset = 1'b0;
        step();
        check("t1_e1_valid", 8'(valid1), 8'h00);
        step();
        check("t1_e2_valid", 8'(valid1), 8'h01);
        check("t1_e2_o", o1, 8'h81);
        check("t8_e2_valid", 8'(valid8), 8'h00);
        for (int k = 0; k < 100; k++) begin
            step();
            check("t1_hold_valid", 8'(valid1), 8'h01);
            check("t1_hold_changed", 8'(changed1), 8'h00);
        end
        check("t1_cnt_sat", 8'(dut1.cnt), 8'h01);
        check("t1_o_final", o1, 8'h81);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
